tipi_pi_bus_gen2: RTL and testbench

//  Parametrised Pi-side register bus for the TIPI CPLD: BUS_W-bit data bus, DATA_W-bit TD/TC/RD/RC registers.

---
 rtl/tipi_pibus_pkg.sv | 22 ++
 rtl/tipi_strobe_sync.sv | 33 +++
 rtl/tipi_pi_bus_gen2.sv | 223 ++++++++++++++++++++++
 tb/tb_tipi_pi_bus_gen2.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tipi_pibus_pkg.sv
// Shared definitions for the TIPI Pi-side register bus: register selects,
// frame state encoding and the beats-per-word helper.
package tipi_pibus_pkg;

  // Header select codes carried in data_in[1:0] of the header beat
  localparam logic [1:0] SEL_TD = 2'd0;
  localparam logic [1:0] SEL_TC = 2'd1;
  localparam logic [1:0] SEL_RD = 2'd2;
  localparam logic [1:0] SEL_RC = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } pibus_state_e;

  // Number of data beats needed to move one DATA_W-bit register
  function automatic int nbeats(input int data_w, input int bus_w);
    return data_w / bus_w;
  endfunction

endpackage

// File: rtl/tipi_strobe_sync.sv
// Brings the asynchronous Pi strobe into the clk domain and turns each
// rising edge into a single-cycle registered pulse, asserted on the 3rd
// clk edge after the strobe rises.
module tipi_strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);

  logic sync1_r;
  logic sync2_r;
  logic sync3_r;
  logic rise_r;

  // Two-flop synchroniser, one history flop and a registered edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      sync1_r <= async_in;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      rise_r  <= sync2_r & ~sync3_r;
    end
  end

  assign rise_pulse = rise_r;

endmodule

// File: rtl/tipi_pi_bus_gen2.sv
// Pi-side register bus for the TIPI CPLD. One header beat selects TD/TC
// (Pi reads) or RD/RC (Pi writes), followed by DATA_W/BUS_W data beats,
// MSB chunk first. Optional frame timeout: define TIPI_PIBUS_TIMEOUT_EN.
module tipi_pi_bus_gen2
  import tipi_pibus_pkg::*;
#(
  parameter int BUS_W       = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pi_strb,
  input  logic [BUS_W-1:0]  data_in,
  output logic [BUS_W-1:0]  data_out,
  output logic              data_oe,
  input  logic [DATA_W-1:0] TD,
  input  logic [DATA_W-1:0] TC,
  output logic [DATA_W-1:0] RD,
  output logic [DATA_W-1:0] RC,
  output logic              rd_wr,
  output logic              rc_wr,
  output logic              busy,
  output logic              frame_abort
);

  localparam int NB    = nbeats(DATA_W, BUS_W);
  localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);

  if ((BUS_W < 2) || ((DATA_W % BUS_W) != 0) || (TIMEOUT_CYC < 2)) begin : g_param_check
    $error("tipi_pi_bus_gen2: BUS_W must be >= 2, DATA_W a multiple of BUS_W, TIMEOUT_CYC >= 2");
  end

  logic              beat_s;
  pibus_state_e      state_r, state_s;
  logic [DATA_W-1:0] shift_r, shift_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic              sel_rc_r, sel_rc_s;
  logic [DATA_W-1:0] rd_r, rd_s;
  logic [DATA_W-1:0] rc_r, rc_s;
  logic              oe_r, oe_s;
  logic [BUS_W-1:0]  dout_r, dout_s;
  logic              rd_wr_r, rd_wr_s;
  logic              rc_wr_r, rc_wr_s;
  logic              busy_r, busy_s;
  logic              abort_r, abort_s;

`ifdef TIPI_PIBUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_r, tmo_s;
`endif

  tipi_strobe_sync u_strobe_sync (
    .clk        (clk),
    .reset      (reset),
    .async_in   (pi_strb),
    .rise_pulse (beat_s)
  );

  // Next-state, datapath and output decode for the frame sequencer
  always_comb begin
    state_s  = state_r;
    shift_s  = shift_r;
    cnt_s    = cnt_r;
    sel_rc_s = sel_rc_r;
    rd_s     = rd_r;
    rc_s     = rc_r;
    oe_s     = oe_r;
    rd_wr_s  = 1'b0;
    rc_wr_s  = 1'b0;
    abort_s  = 1'b0;
`ifdef TIPI_PIBUS_TIMEOUT_EN
    tmo_s    = tmo_r;
`endif

    case (state_r)
      IDLE: begin
        if (beat_s) begin
          cnt_s = '0;
          case (data_in[1:0])
            SEL_TD: begin
              shift_s = TD;
              oe_s    = 1'b1;
              state_s = READ;
            end
            SEL_TC: begin
              shift_s = TC;
              oe_s    = 1'b1;
              state_s = READ;
            end
            SEL_RD: begin
              sel_rc_s = 1'b0;
              state_s  = WRITE;
            end
            SEL_RC: begin
              sel_rc_s = 1'b1;
              state_s  = WRITE;
            end
            default: begin
              state_s = IDLE;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end

      READ: begin
        if (beat_s) begin
          shift_s = shift_r << BUS_W;
          if (cnt_r == CNT_LAST) begin
            oe_s    = 1'b0;
            cnt_s   = '0;
            state_s = IDLE;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_s = READ;
        end
      end

      WRITE: begin
        if (beat_s) begin
          shift_s = (shift_r << BUS_W) | DATA_W'(data_in);
          if (cnt_r == CNT_LAST) begin
            if (sel_rc_r) begin
              rc_s    = shift_s;
              rc_wr_s = 1'b1;
            end else begin
              rd_s    = shift_s;
              rd_wr_s = 1'b1;
            end
            cnt_s   = '0;
            state_s = IDLE;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          state_s = WRITE;
        end
      end

      default: begin
        state_s = IDLE;
        oe_s    = 1'b0;
        cnt_s   = '0;
      end
    endcase

`ifdef TIPI_PIBUS_TIMEOUT_EN
    // A beat always restarts the idle-time count; an expired count abandons the frame
    if (beat_s) begin
      tmo_s = '0;
    end else if (state_r != IDLE) begin
      if (tmo_r == TMO_LAST) begin
        tmo_s   = '0;
        state_s = IDLE;
        oe_s    = 1'b0;
        cnt_s   = '0;
        shift_s = '0;
        abort_s = 1'b1;
      end else begin
        tmo_s = tmo_r + TMO_W'(1);
      end
    end else begin
      tmo_s = '0;
    end
`endif

    dout_s = shift_s[DATA_W-1 -: BUS_W];
    busy_s = (state_s != IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      shift_r  <= '0;
      cnt_r    <= '0;
      sel_rc_r <= 1'b0;
      rd_r     <= '0;
      rc_r     <= '0;
      oe_r     <= 1'b0;
      dout_r   <= '0;
      rd_wr_r  <= 1'b0;
      rc_wr_r  <= 1'b0;
      busy_r   <= 1'b0;
      abort_r  <= 1'b0;
`ifdef TIPI_PIBUS_TIMEOUT_EN
      tmo_r    <= '0;
`endif
    end else begin
      state_r  <= state_s;
      shift_r  <= shift_s;
      cnt_r    <= cnt_s;
      sel_rc_r <= sel_rc_s;
      rd_r     <= rd_s;
      rc_r     <= rc_s;
      oe_r     <= oe_s;
      dout_r   <= dout_s;
      rd_wr_r  <= rd_wr_s;
      rc_wr_r  <= rc_wr_s;
      busy_r   <= busy_s;
      abort_r  <= abort_s;
`ifdef TIPI_PIBUS_TIMEOUT_EN
      tmo_r    <= tmo_s;
`endif
    end
  end

  assign data_out    = dout_r;
  assign data_oe     = oe_r;
  assign RD          = rd_r;
  assign RC          = rc_r;
  assign rd_wr       = rd_wr_r;
  assign rc_wr       = rc_wr_r;
  assign busy        = busy_r;
  assign frame_abort = abort_r;

endmodule

// File: tb/tb_tipi_pi_bus_gen2.sv
// Self-checking bench for tipi_pi_bus_gen2: a vector table of frames, a few
// hand-written corner sequences, and randomized frames checked against a
// register-level model of what the Pi should read and write.
module tb_tipi_pi_bus_gen2;
  import tipi_pibus_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  // DUT A: BUS_W=4, DATA_W=8
  logic       strb_a;
  logic [3:0] din_a, dout_a;
  logic       oe_a;
  logic [7:0] td_a, tc_a, rd_a, rc_a;
  logic       rd_wr_a, rc_wr_a, busy_a, abort_a;
  // DUT B: BUS_W=2, DATA_W=8
  logic       strb_b;
  logic [1:0] din_b, dout_b;
  logic       oe_b;
  logic [7:0] td_b, tc_b, rd_b, rc_b;
  logic       rd_wr_b, rc_wr_b, busy_b, abort_b;

  tipi_pi_bus_gen2 #(.BUS_W(4), .DATA_W(8), .TIMEOUT_CYC(64)) u_dut_a (
    .clk(clk), .reset(reset), .pi_strb(strb_a), .data_in(din_a),
    .data_out(dout_a), .data_oe(oe_a), .TD(td_a), .TC(tc_a),
    .RD(rd_a), .RC(rc_a), .rd_wr(rd_wr_a), .rc_wr(rc_wr_a),
    .busy(busy_a), .frame_abort(abort_a)
  );

  tipi_pi_bus_gen2 #(.BUS_W(2), .DATA_W(8), .TIMEOUT_CYC(64)) u_dut_b (
    .clk(clk), .reset(reset), .pi_strb(strb_b), .data_in(din_b),
    .data_out(dout_b), .data_oe(oe_b), .TD(td_b), .TC(tc_b),
    .RD(rd_b), .RC(rc_b), .rd_wr(rd_wr_b), .rc_wr(rc_wr_b),
    .busy(busy_b), .frame_abort(abort_b)
  );

  int total = 0;
  int bad   = 0;
  int rd_wr_n = 0, rc_wr_n = 0, abort_n = 0, overlap_n = 0, rd_wr_b_n = 0;
  logic [7:0] exp_rd, exp_rc;

  // Count pulse cycles away from the active edge
  always @(negedge clk) begin
    if (rd_wr_a) rd_wr_n <= rd_wr_n + 1;
    if (rc_wr_a) rc_wr_n <= rc_wr_n + 1;
    if (abort_a) abort_n <= abort_n + 1;
    if (rd_wr_a && rc_wr_a) overlap_n <= overlap_n + 1;
    if (rd_wr_b) rd_wr_b_n <= rd_wr_b_n + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One Pi beat on DUT A: strobe high 4 clk with data held, then low 4 clk
  task automatic beat_a(input logic [3:0] d);
    din_a  = d;
    strb_a = 1'b1;
    tick(4);
    strb_a = 1'b0;
    tick(4);
  endtask

  task automatic beat_b(input logic [1:0] d);
    din_b  = d;
    strb_b = 1'b1;
    tick(4);
    strb_b = 1'b0;
    tick(4);
  endtask

  // Pi reads a register: each chunk must be on the pads before its beat
  task automatic read_frame(input logic [1:0] sel, input logic [7:0] word, input string nm);
    int w;
    logic [1:0] junk;
    junk = 2'($urandom_range(0, 3));
    w = int'(word);
    beat_a({junk, sel});
    for (int i = 0; i < 2; i++) begin
      chk({nm, "_oe"}, 32'(oe_a), 32'd1);
      chk({nm, "_chunk"}, 32'(dout_a), 32'((w >> (4 * (1 - i))) & 15));
      beat_a(4'h0);
    end
    chk({nm, "_oe_end"}, 32'(oe_a), 32'd0);
    chk({nm, "_busy_end"}, 32'(busy_a), 32'd0);
  endtask

  // Pi writes RD/RC: register, strobe pulse counts and the untouched register
  task automatic write_frame(input logic [1:0] sel, input logic [7:0] word, input string nm);
    int rd0, rc0, w;
    logic [1:0] junk;
    rd0 = rd_wr_n;
    rc0 = rc_wr_n;
    w = int'(word);
    junk = 2'($urandom_range(0, 3));
    beat_a({junk, sel});
    for (int i = 0; i < 2; i++) beat_a(4'((w >> (4 * (1 - i))) & 15));
    if (sel == SEL_RD) exp_rd = word;
    else exp_rc = word;
    chk({nm, "_RD"}, 32'(rd_a), 32'(exp_rd));
    chk({nm, "_RC"}, 32'(rc_a), 32'(exp_rc));
    chk({nm, "_rd_wr_cycles"}, 32'(rd_wr_n - rd0), (sel == SEL_RD) ? 32'd1 : 32'd0);
    chk({nm, "_rc_wr_cycles"}, 32'(rc_wr_n - rc0), (sel == SEL_RC) ? 32'd1 : 32'd0);
    chk({nm, "_busy_end"}, 32'(busy_a), 32'd0);
  endtask

  typedef struct {
    logic [1:0] sel;
    logic [7:0] td;
    logic [7:0] tc;
    logic [7:0] word;
    logic [7:0] exp;   // word the Pi reads, or value the written register holds
  } vec_t;

  vec_t vecs[7];

  initial begin
    int rb0, a0;
    logic [1:0] s;
    logic [7:0] t, c, wv;

    vecs[0] = '{sel: SEL_TD, td: 8'hA5, tc: 8'h3C, word: 8'h00, exp: 8'hA5};
    vecs[1] = '{sel: SEL_RC, td: 8'hA5, tc: 8'h3C, word: 8'h7C, exp: 8'h7C};
    vecs[2] = '{sel: SEL_TC, td: 8'h00, tc: 8'h3C, word: 8'h00, exp: 8'h3C};
    vecs[3] = '{sel: SEL_RD, td: 8'h00, tc: 8'h00, word: 8'hFF, exp: 8'hFF};
    vecs[4] = '{sel: SEL_RD, td: 8'h00, tc: 8'h00, word: 8'h00, exp: 8'h00};
    vecs[5] = '{sel: SEL_RC, td: 8'h12, tc: 8'h34, word: 8'h81, exp: 8'h81};
    vecs[6] = '{sel: SEL_TC, td: 8'h12, tc: 8'hF0, word: 8'h00, exp: 8'hF0};

    reset = 1'b1;
    strb_a = 1'b0; din_a = 4'h0; td_a = 8'h00; tc_a = 8'h00;
    strb_b = 1'b0; din_b = 2'd0; td_b = 8'h00; tc_b = 8'h00;
    exp_rd = 8'h00; exp_rc = 8'h00;
    tick(3);
    chk("rst_data_out", 32'(dout_a), 32'd0);
    chk("rst_data_oe", 32'(oe_a), 32'd0);
    chk("rst_RD", 32'(rd_a), 32'd0);
    chk("rst_RC", 32'(rc_a), 32'd0);
    chk("rst_pulses", 32'({rd_wr_a, rc_wr_a, abort_a}), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    reset = 1'b0;
    tick(2);

    // Vector table
    foreach (vecs[i]) begin
      td_a = vecs[i].td;
      tc_a = vecs[i].tc;
      if (vecs[i].sel == SEL_TD || vecs[i].sel == SEL_TC)
        read_frame(vecs[i].sel, vecs[i].exp, $sformatf("vec%0d", i));
      else begin
        write_frame(vecs[i].sel, vecs[i].word, $sformatf("vec%0d", i));
        chk($sformatf("vec%0d_reg", i),
            32'((vecs[i].sel == SEL_RD) ? rd_a : rc_a), 32'(vecs[i].exp));
      end
    end

    // TD changes after the header must not disturb the frame in progress
    td_a = 8'h11;
    beat_a(4'h0);
    chk("snap_chunk0", 32'(dout_a), 32'h1);
    td_a = 8'hFF;
    tick(2);
    beat_a(4'h0);
    chk("snap_chunk1", 32'(dout_a), 32'h1);
    beat_a(4'h0);
    chk("snap_oe_end", 32'(oe_a), 32'd0);

    // Reset mid-write discards the partial word
    beat_a(4'h2);
    beat_a(4'h9);
    chk("midrst_busy_before", 32'(busy_a), 32'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_rd = 8'h00;
    exp_rc = 8'h00;
    chk("midrst_RD", 32'(rd_a), 32'd0);
    chk("midrst_busy", 32'(busy_a), 32'd0);
    chk("midrst_oe", 32'(oe_a), 32'd0);
    tick(2);
    write_frame(SEL_RD, 8'h34, "postrst");

    // BUS_W=2: four data beats MSB first
    rb0 = rd_wr_b_n;
    beat_b(2'b10);
    beat_b(2'd2);
    beat_b(2'd3);
    beat_b(2'd1);
    beat_b(2'd0);
    chk("w2_RD", 32'(rd_b), 32'hB4);
    chk("w2_RC", 32'(rc_b), 32'h00);
    chk("w2_rd_wr_cycles", 32'(rd_wr_b_n - rb0), 32'd1);

    // Long gap in the middle of a write frame
    a0 = abort_n;
    beat_a(4'h2);
    beat_a(4'h9);
    tick(100);
`ifdef TIPI_PIBUS_TIMEOUT_EN
    chk("tmo_abort_cycles", 32'(abort_n - a0), 32'd1);
    chk("tmo_busy", 32'(busy_a), 32'd0);
    chk("tmo_RD_kept", 32'(rd_a), 32'(exp_rd));
    write_frame(SEL_RD, 8'h5A, "tmo_next_hdr");
`else
    chk("gap_busy", 32'(busy_a), 32'd1);
    chk("gap_no_abort", 32'(abort_n - a0), 32'd0);
    beat_a(4'h1);
    exp_rd = 8'h91;
    chk("gap_RD", 32'(rd_a), 32'h91);
    chk("gap_busy_end", 32'(busy_a), 32'd0);
`endif

    // Randomized frames against the register-level model
    for (int n = 0; n < 24; n++) begin
      s  = 2'($urandom_range(0, 3));
      t  = 8'($urandom_range(0, 255));
      c  = 8'($urandom_range(0, 255));
      wv = 8'($urandom_range(0, 255));
      td_a = t;
      tc_a = c;
      if (s == SEL_TD) read_frame(s, t, $sformatf("rnd%0d", n));
      else if (s == SEL_TC) read_frame(s, c, $sformatf("rnd%0d", n));
      else write_frame(s, wv, $sformatf("rnd%0d", n));
    end

    chk("commit_overlap", 32'(overlap_n), 32'd0);
`ifndef TIPI_PIBUS_TIMEOUT_EN
    chk("abort_never", 32'(abort_n), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
